// File: rtl/register_file_param_if.sv
// Register file port bundle: two registered read channels, one write channel, ready flag.
// The register file drives ready and both read-data buses; the pipeline drives everything else.
interface register_file_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);

  logic              ready;

  logic              r_1_en;
  logic [ADDR_W-1:0] addr_r_1;
  logic [DATA_W-1:0] r_data_1;

  logic              r_2_en;
  logic [ADDR_W-1:0] addr_r_2;
  logic [DATA_W-1:0] r_data_2;

  logic              w_en;
  logic [ADDR_W-1:0] addr_w;
  logic [DATA_W-1:0] w_data;

  // Pipeline side (decode + writeback)
  modport master (
    input  ready,
    output r_1_en, addr_r_1,
    input  r_data_1,
    output r_2_en, addr_r_2,
    input  r_data_2,
    output w_en, addr_w, w_data
  );

  // Register file side
  modport slave (
    output ready,
    input  r_1_en, addr_r_1,
    output r_data_1,
    input  r_2_en, addr_r_2,
    output r_data_2,
    input  w_en, addr_w, w_data
  );

endinterface

// File: rtl/register_file_param.sv
// Parametrised 2R1W register file with post-reset clear sweep and optional hardwired-zero reg 0.
// Define REGFILE_BYPASS_EN to forward same-edge write data to a matching read.
module register_file_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  register_file_param_if.slave bus
);

  localparam int unsigned     DEPTH    = 1 << ADDR_W;
  localparam int unsigned     CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEPTH - 1);
  localparam bit              HAS_ZERO = (ZERO_REG != 0);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              w_fire_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [DATA_W-1:0] rd_1_c;
  logic [DATA_W-1:0] rd_2_c;

  // A write lands unless it targets the hardwired-zero register
  always_comb begin
    w_fire_c = bus.w_en;
    if (HAS_ZERO && (bus.addr_w == '0)) w_fire_c = 1'b0;
  end

  // Read data selection: array value, optional forwarding, then zero-register override
  always_comb begin
    rd_1_c = mem[bus.addr_r_1];
    rd_2_c = mem[bus.addr_r_2];
`ifdef REGFILE_BYPASS_EN
    if (w_fire_c && (bus.addr_w == bus.addr_r_1)) rd_1_c = bus.w_data;
    if (w_fire_c && (bus.addr_w == bus.addr_r_2)) rd_2_c = bus.w_data;
`endif
    if (HAS_ZERO && (bus.addr_r_1 == '0)) rd_1_c = '0;
    if (HAS_ZERO && (bus.addr_r_2 == '0)) rd_2_c = '0;
  end

  // Single array write port shared by the clear sweep and the pipeline writeback
  always_comb begin
    mem_we_c    = 1'b0;
    mem_addr_c  = cnt[ADDR_W-1:0];
    mem_wdata_c = '0;
    if (rst_n) begin
      if (state == INIT) begin
        mem_we_c = 1'b1;
      end else if (w_fire_c) begin
        mem_we_c    = 1'b1;
        mem_addr_c  = bus.addr_w;
        mem_wdata_c = bus.w_data;
      end
    end
  end

  // Storage is never reset directly; the sweep zeroes it instead
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_addr_c] <= mem_wdata_c;
  end

  // Control FSM with registered ready and read-data outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= INIT;
      cnt          <= '0;
      bus.ready    <= 1'b0;
      bus.r_data_1 <= '0;
      bus.r_data_2 <= '0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state     <= RUN;
            bus.ready <= 1'b1;
          end
        end
        RUN: begin
          if (bus.r_1_en) bus.r_data_1 <= rd_1_c;
          if (bus.r_2_en) bus.r_data_2 <= rd_2_c;
        end
        default: begin
          state     <= INIT;
          cnt       <= '0;
          bus.ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/register_file_param.md
# register_file_param

Parametrised successor to the MIPS register file: a DATA_W x 2^ADDR_W register array with two independently enabled registered read ports and one write port. It adds a synchronous active-low reset, a hardware clear sequencer that zeroes every register after reset, an optional hardwired-zero register 0, and an optional write-to-read bypass. It sits between instruction decode (read addresses) and writeback (write port) in the soft MIPS core.

## Interface

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth is DEPTH = 2^ADDR_W.
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes; 0 = register 0 is ordinary.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- ready  output  1  1 = clear sweep finished, ports accepted.
- r_1_en  input  1  read enable, channel 1.
- addr_r_1  input  ADDR_W  read address, channel 1.
- r_data_1  output  DATA_W  registered read data, channel 1.
- r_2_en  input  1  read enable, channel 2.
- addr_r_2  input  ADDR_W  read address, channel 2.
- r_data_2  output  DATA_W  registered read data, channel 2.
- w_en  input  1  write enable.
- addr_w  input  ADDR_W  write address.
- w_data  input  DATA_W  write data.

## Operation

- States: INIT (clear sweep) and RUN. An ADDR_W+1-bit sweep counter cnt is used in INIT only.
- Edge with rst_n=0: state=INIT, cnt=0, ready=0, r_data_1=r_data_2=0. Array contents are not touched on this edge.
- INIT, edge with rst_n=1: mem[cnt]<=0, cnt<=cnt+1. The edge that clears mem[DEPTH-1] sets state=RUN and ready=1.
- INIT: w_en, r_1_en and r_2_en are ignored, and r_data_x holds 0.
- RUN, write: on an edge with w_en=1, mem[addr_w]<=w_data. When ZERO_REG=1 and addr_w=0, the write is discarded.
- RUN, read: on an edge with r_x_en=1, r_data_x<=mem[addr_r_x]. The array value used is the one before that edge's write, unless bypass is compiled in. When ZERO_REG=1 and addr_r_x=0, the result is 0.
- RUN, read disabled (r_x_en=0): r_data_x holds its previous value.
- The two channels are fully independent. Both may read the same address on the same edge.
- Reset mid-operation (rst_n=0 in any state or cycle): returns to INIT and restarts the sweep from cnt=0. All registers are re-cleared.
- No out-of-range addresses exist, because the depth is a full power of two.

## Timing

- Reset values: ready=0, r_data_1=0, r_data_2=0.
- ready rises exactly DEPTH rising edges after the first edge on which rst_n=1. For defaults this is 32 edges.
- An input is acted on only at an edge where ready was already 1 before that edge. The edge that raises ready ignores the ports.
- Read latency is 1 cycle: an address presented before edge k appears on r_data_x after edge k.
- Write latency is 1 cycle. Without bypass, a read of the same address issued at edge k+1 or later returns the new data.
- Simultaneous write and read to the same address at the same edge: the result depends on Configuration.

## Configuration

- Macro: REGFILE_BYPASS_EN.
- Defined: same-edge forwarding. If w_en=1, addr_w==addr_r_x, r_x_en=1 and the write is not discarded, then r_data_x<=w_data. With ZERO_REG=1 and address 0, the result is still 0.
- Undefined: no forwarding. r_data_x gets the pre-write array value (read-before-write).

## Test plan

- Reset/clear: hold rst_n=0 for 3 edges, release, then count edges. Required: ready=0 for the first 31 edges and 1 after the 32nd. All r_data=0 throughout. Reading addresses 0..31 afterwards returns 0 on both channels.
- Basic write/read: write 0xAAAA to reg 10, then r_1_en=1 addr 10, then r_2_en=1 addr 10. Required: r_data_1=0xAAAA one edge after its read. r_data_2=0xAAAA one edge after its read. r_data_1 holds 0xAAAA while r_1_en=0.
- Zero register (ZERO_REG=1): write 0x1234 to reg 0, then read reg 0 on both channels. Required: both return 0. With ZERO_REG=0, both return 0x1234.
- Same-edge collision: reg 5=0x11, then w_en with addr 5 and data 0x22 while r_1_en reads addr 5 on the same edge. Required: r_data_1=0x22 with REGFILE_BYPASS_EN, 0x11 without it. The next read of reg 5 returns 0x22 in both builds.
- Ignored during INIT: drive w_en=1, addr 7, data 0xDEAD, and r_1_en=1, throughout the sweep. Required: r_data_1 stays 0, and reg 7 reads 0 after ready.
- Reset mid-operation: write 0xBEEF to reg 3, then assert rst_n=0 for 1 edge mid-run. Required: ready drops on that edge and r_data returns to 0. ready re-rises 32 edges after release, and reg 3 then reads 0.
